// File: rtl/seg_display_arbiter.sv
// Shares a 6-digit hex display between a background value and two event sources.
// Events preempt the background for HOLD_MS; contending events are served round-robin.
//
// state | meaning
// IDLE  | background shown, no event pending
// SHOW0 | ev0 data on display, hold timer running
// SHOW1 | ev1 data on display, hold timer running
module seg_display_arbiter #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int HOLD_MS  = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] bg_data,
    input  logic        ev0_valid,
    input  logic [23:0] ev0_data,
    output logic        ev0_ready,
    input  logic        ev1_valid,
    input  logic [23:0] ev1_data,
    output logic        ev1_ready,
    output logic [23:0] disp_data,
    output logic [1:0]  disp_src,
    output logic        ev_active
);
    localparam int TICKS_PER_MS = CLK_FREQ / 1000;
    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);
    localparam logic [15:0]   HOLD_LAST  = 16'(HOLD_MS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW0 = 2'd1,
        SHOW1 = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       buf_full;
    logic [1:0][23:0] buf_data;
    logic             last_served;
    logic [PW-1:0]    presc;
    logic [15:0]      hold_cnt;

    logic [1:0][23:0] ev_data;
    logic [1:0]       xfer;
    logic             sx;
    logic             sy;
    logic             idle_pick;
    logic             tick;
    logic             expire;

    assign ev_data   = {ev1_data, ev0_data};
    assign ev0_ready = !rst && (!buf_full[0] || state == SHOW0);
    assign ev1_ready = !rst && (!buf_full[1] || state == SHOW1);
    assign xfer      = {ev1_valid && ev1_ready, ev0_valid && ev0_ready};

    // sx is the source on display, sy the other one
    assign sx        = (state == SHOW1);
    assign sy        = !sx;
    assign idle_pick = (&xfer) ? !last_served : xfer[1];
    assign tick      = (presc == PRESC_LAST);
    assign expire    = tick && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            disp_data   <= '0;
            disp_src    <= 2'd0;
            ev_active   <= 1'b0;
            buf_full    <= '0;
            buf_data    <= '0;
            last_served <= 1'b1;
            presc       <= '0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|xfer) begin
                        state       <= idle_pick ? SHOW1 : SHOW0;
                        disp_data   <= ev_data[idle_pick];
                        disp_src    <= {idle_pick, !idle_pick};
                        ev_active   <= 1'b1;
                        last_served <= idle_pick;
                        presc       <= '0;
                        hold_cnt    <= '0;
                        if (&xfer) begin
                            buf_full[!idle_pick] <= 1'b1;
                            buf_data[!idle_pick] <= ev_data[!idle_pick];
                        end
                    end else begin
                        disp_data <= bg_data;
                        disp_src  <= 2'd0;
                        ev_active <= 1'b0;
                    end
                end
                SHOW0, SHOW1: begin
                    if (xfer[sx]) begin
                        // refresh from the shown source wins over expiry
                        disp_data <= ev_data[sx];
                        presc     <= '0;
                        hold_cnt  <= '0;
                        if (xfer[sy]) begin
                            buf_full[sy] <= 1'b1;
                            buf_data[sy] <= ev_data[sy];
                        end
                    end else if (expire) begin
                        if (xfer[sy] || buf_full[sy]) begin
                            state        <= sy ? SHOW1 : SHOW0;
                            disp_data    <= xfer[sy] ? ev_data[sy] : buf_data[sy];
                            disp_src     <= {sy, sx};
                            buf_full[sy] <= 1'b0;
                            last_served  <= sy;
                            presc        <= '0;
                            hold_cnt     <= '0;
                        end else if (buf_full[sx]) begin
                            disp_data    <= buf_data[sx];
                            buf_full[sx] <= 1'b0;
                            presc        <= '0;
                            hold_cnt     <= '0;
                        end else begin
                            state     <= IDLE;
                            disp_data <= bg_data;
                            disp_src  <= 2'd0;
                            ev_active <= 1'b0;
                        end
                    end else begin
                        if (xfer[sy]) begin
                            buf_full[sy] <= 1'b1;
                            buf_data[sy] <= ev_data[sy];
                        end
                        if (tick) begin
                            presc    <= '0;
                            hold_cnt <= hold_cnt + 16'd1;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
